// File: rtl/initialization_command_sequencer.sv
// ICW/OCW write decoder for an 8259-style interrupt controller.
// It walks the ICW1..ICW4 init sequence, then decodes OCW writes into one-cycle strobes.
module initialization_command_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_strobe,
  input  logic       address_0,
  input  logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1_registers,
  output logic       write_operation_control_word_2_registers,
  output logic       write_operation_control_word_3_registers,
  output logic       poll_command,
  output logic       initialization_complete,
  output logic       single_or_cascade,
  output logic       level_or_edge_triggered,
  output logic       auto_end_of_interrupt,
  output logic       buffered_mode,
  output logic       buffered_master,
  output logic       special_fully_nested_mode,
  output logic       microprocessor_mode,
  output logic [4:0] interrupt_vector_address,
  output logic [7:0] cascade_device_config,
  output logic       special_mask_mode,
  output logic       read_register_isr_or_irr
);

  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;

  state_t     state_d, state_q;
  logic       ic4_q;
  logic       icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q, ocw2_q, ocw3_q, poll_q, init_q;
  logic       sngl_q, ltim_q, aeoi_q, buf_q, msl_q, sfnm_q, upm_q, smm_q, rr_q;
  logic [4:0] iva_q;
  logic [7:0] cas_q;
  logic       is_icw1;

  // ICW1 is recognised in every state, so it can restart a sequence at any time.
  assign is_icw1 = !address_0 && internal_data_bus[4];

  always_comb begin
    state_d = state_q;
    if (write_strobe) begin
      if (is_icw1) begin
        state_d = WAIT_ICW2;
      end else if (address_0) begin
        case (state_q)
          WAIT_ICW2: state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
          WAIT_ICW3: state_d = ic4_q ? WAIT_ICW4 : READY;
          WAIT_ICW4: state_d = READY;
          default:   state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ic4_q   <= 1'b0;
      {icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q, ocw2_q, ocw3_q, poll_q, init_q} <= '0;
      {sngl_q, ltim_q, aeoi_q, buf_q, msl_q, sfnm_q, upm_q, smm_q, rr_q} <= '0;
      iva_q   <= '0;
      cas_q   <= '0;
    end else begin
      {icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q, ocw2_q, ocw3_q, poll_q} <= '0;
      state_q <= state_d;
      init_q  <= (state_d == READY);
      if (write_strobe) begin
        if (is_icw1) begin
          icw1_q <= 1'b1;
          ic4_q  <= internal_data_bus[0];
          sngl_q <= internal_data_bus[1];
          ltim_q <= internal_data_bus[3];
          {aeoi_q, buf_q, msl_q, sfnm_q, upm_q, smm_q, rr_q} <= '0;
        end else if (address_0) begin
          case (state_q)
            WAIT_ICW2: begin
              icw2_q <= 1'b1;
              iva_q  <= internal_data_bus[7:3];
            end
            WAIT_ICW3: begin
              icw3_q <= 1'b1;
              cas_q  <= internal_data_bus;
            end
            WAIT_ICW4: begin
              icw4_q <= 1'b1;
              upm_q  <= internal_data_bus[0];
              aeoi_q <= internal_data_bus[1];
              msl_q  <= internal_data_bus[2];
              buf_q  <= internal_data_bus[3];
              sfnm_q <= internal_data_bus[4];
            end
            READY:   ocw1_q <= 1'b1;
            default: ;
          endcase
        end else if (state_q == READY) begin
          // A0=0, D4=0 here: D3 splits OCW2 from OCW3.
          if (!internal_data_bus[3]) begin
            ocw2_q <= 1'b1;
          end else begin
            ocw3_q <= 1'b1;
            if (internal_data_bus[6]) smm_q <= internal_data_bus[5];
            if (internal_data_bus[1]) rr_q  <= internal_data_bus[0];
            poll_q <= internal_data_bus[2];
          end
        end
      end
    end
  end

  assign write_initial_command_word_1             = icw1_q;
  assign write_initial_command_word_2             = icw2_q;
  assign write_initial_command_word_3             = icw3_q;
  assign write_initial_command_word_4             = icw4_q;
  assign write_operation_control_word_1_registers = ocw1_q;
  assign write_operation_control_word_2_registers = ocw2_q;
  assign write_operation_control_word_3_registers = ocw3_q;
  assign poll_command                             = poll_q;
  assign initialization_complete                  = init_q;
  assign single_or_cascade                        = sngl_q;
  assign level_or_edge_triggered                  = ltim_q;
  assign auto_end_of_interrupt                    = aeoi_q;
  assign buffered_mode                            = buf_q;
  assign buffered_master                          = msl_q;
  assign special_fully_nested_mode                = sfnm_q;
  assign microprocessor_mode                      = upm_q;
  assign interrupt_vector_address                 = iva_q;
  assign cascade_device_config                    = cas_q;
  assign special_mask_mode                        = smm_q;
  assign read_register_isr_or_irr                 = rr_q;

endmodule

// File: tb/tb_initialization_command_sequencer.sv
// Scoreboard bench for initialization_command_sequencer: a behavioural model queues the
// expected output vector per driven cycle, and each scenario task pops and compares it.
module tb_initialization_command_sequencer;

  logic       clock = 1'b0;
  logic       reset, write_strobe, address_0;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, poll, initc;
  logic       sngl, ltim, aeoi, bufm, bmst, sfnm, upm, smm, rr;
  logic [4:0] iva;
  logic [7:0] cas;

  typedef struct packed {
    logic icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, poll, initc;
    logic sngl, ltim, aeoi, bufm, bmst, sfnm, upm;
    logic [4:0] iva;
    logic [7:0] cas;
    logic smm, rr;
  } outv_t;

  outv_t sb[$];
  outv_t m_o;
  int    m_st;    // 0 IDLE, 1 WAIT_ICW2, 2 WAIT_ICW3, 3 WAIT_ICW4, 4 READY
  logic  m_ic4;
  int    nvec = 0;
  int    nmis = 0;

  always #5 clock = ~clock;

  initialization_command_sequencer dut (
    .clock(clock), .reset(reset), .write_strobe(write_strobe), .address_0(address_0),
    .internal_data_bus(internal_data_bus),
    .write_initial_command_word_1(icw1), .write_initial_command_word_2(icw2),
    .write_initial_command_word_3(icw3), .write_initial_command_word_4(icw4),
    .write_operation_control_word_1_registers(ocw1),
    .write_operation_control_word_2_registers(ocw2),
    .write_operation_control_word_3_registers(ocw3),
    .poll_command(poll), .initialization_complete(initc),
    .single_or_cascade(sngl), .level_or_edge_triggered(ltim),
    .auto_end_of_interrupt(aeoi), .buffered_mode(bufm), .buffered_master(bmst),
    .special_fully_nested_mode(sfnm), .microprocessor_mode(upm),
    .interrupt_vector_address(iva), .cascade_device_config(cas),
    .special_mask_mode(smm), .read_register_isr_or_irr(rr)
  );

  function automatic outv_t get_obs();
    outv_t o;
    o = '{icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, poll, initc,
          sngl, ltim, aeoi, bufm, bmst, sfnm, upm, iva, cas, smm, rr};
    return o;
  endfunction

  task automatic model_push(input logic rst, input logic ws, input logic a0, input logic [7:0] d);
    outv_t e;
    e = m_o;
    {e.icw1, e.icw2, e.icw3, e.icw4, e.ocw1, e.ocw2, e.ocw3, e.poll} = '0;
    if (rst) begin
      e = '0; m_st = 0; m_ic4 = 1'b0;
    end else if (ws) begin
      if (!a0 && d[4]) begin
        e.icw1 = 1'b1; m_ic4 = d[0]; e.sngl = d[1]; e.ltim = d[3];
        e.aeoi = 0; e.bufm = 0; e.bmst = 0; e.sfnm = 0; e.upm = 0; e.smm = 0; e.rr = 0;
        m_st = 1;
      end else if (a0) begin
        if (m_st == 1) begin
          e.icw2 = 1'b1; e.iva = d[7:3];
          if (!e.sngl) m_st = 2; else if (m_ic4) m_st = 3; else m_st = 4;
        end else if (m_st == 2) begin
          e.icw3 = 1'b1; e.cas = d;
          m_st = m_ic4 ? 3 : 4;
        end else if (m_st == 3) begin
          e.icw4 = 1'b1; e.upm = d[0]; e.aeoi = d[1]; e.bmst = d[2]; e.bufm = d[3]; e.sfnm = d[4];
          m_st = 4;
        end else if (m_st == 4) begin
          e.ocw1 = 1'b1;
        end
      end else if (m_st == 4) begin
        if (d[3] == 1'b0) e.ocw2 = 1'b1;
        else begin
          e.ocw3 = 1'b1;
          if (d[6]) e.smm = d[5];
          if (d[1]) e.rr = d[0];
          e.poll = d[2];
        end
      end
    end
    e.initc = (m_st == 4);
    m_o = e;
    sb.push_back(e);
  endtask

  // Stimulus word: {reset, write_strobe, address_0, data[7:0]}.
  task automatic cycle(input logic [10:0] s);
    @(negedge clock);
    reset = s[10]; write_strobe = s[9]; address_0 = s[8]; internal_data_bus = s[7:0];
    model_push(s[10], s[9], s[8], s[7:0]);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] tbl [3] = '{11'h400, 11'h613, 11'h000};
    outv_t exp;
    for (int i = 0; i < 3; i++) begin
      cycle(tbl[i]);
      exp = sb.pop_front(); nvec++;
      if (get_obs() !== exp) begin
        nmis++; $display("FAIL reset step %0d: got %h want %h", i, get_obs(), exp);
      end
    end
    nvec++;
    if (get_obs() !== outv_t'('0)) begin
      nmis++; $display("FAIL reset_zero: got %h want 0", get_obs());
    end
  endtask

  task automatic test_icw4_path();
    logic [10:0] tbl [4] = '{11'h213, 11'h348, 11'h303, 11'h000};
    outv_t exp;
    for (int i = 0; i < 4; i++) begin
      cycle(tbl[i]);
      exp = sb.pop_front(); nvec++;
      if (get_obs() !== exp) begin
        nmis++; $display("FAIL icw4_path step %0d: got %h want %h", i, get_obs(), exp);
      end
      if (i == 1) begin
        nvec++;
        if (iva !== 5'h09 || icw2 !== 1'b1 || initc !== 1'b0) begin
          nmis++; $display("FAIL icw2_vector: got iva=%h icw2=%b rdy=%b want 09 1 0", iva, icw2, initc);
        end
      end
    end
    nvec++;
    if ({aeoi, upm, initc, sngl} !== 4'b1111) begin
      nmis++; $display("FAIL icw4_fields: got %b want 1111", {aeoi, upm, initc, sngl});
    end
  endtask

  task automatic test_icw3_path();
    logic [10:0] tbl [4] = '{11'h210, 11'h320, 11'h304, 11'h000};
    outv_t exp;
    for (int i = 0; i < 4; i++) begin
      cycle(tbl[i]);
      exp = sb.pop_front(); nvec++;
      if (get_obs() !== exp) begin
        nmis++; $display("FAIL icw3_path step %0d: got %h want %h", i, get_obs(), exp);
      end
    end
    nvec++;
    if (cas !== 8'h04 || initc !== 1'b1 || {aeoi, upm, bufm, bmst, sfnm} !== 5'b0) begin
      nmis++; $display("FAIL icw3_result: got cas=%h rdy=%b icw4bits=%b want 04 1 00000",
                       cas, initc, {aeoi, upm, bufm, bmst, sfnm});
    end
  endtask

  task automatic test_ocw();
    logic [10:0] tbl [5] = '{11'h3FF, 11'h000, 11'h268, 11'h20C, 11'h000};
    outv_t exp;
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i]);
      exp = sb.pop_front(); nvec++;
      if (get_obs() !== exp) begin
        nmis++; $display("FAIL ocw step %0d: got %h want %h", i, get_obs(), exp);
      end
      if (i == 3) begin
        nvec++;
        if ({poll, ocw3, smm} !== 3'b111) begin
          nmis++; $display("FAIL ocw3_poll: got %b want 111", {poll, ocw3, smm});
        end
      end
    end
  endtask

  task automatic test_ignore_mid();
    logic [10:0] tbl [4] = '{11'h213, 11'h220, 11'h213, 11'h000};
    outv_t exp;
    for (int i = 0; i < 4; i++) begin
      cycle(tbl[i]);
      exp = sb.pop_front(); nvec++;
      if (get_obs() !== exp) begin
        nmis++; $display("FAIL ignore_mid step %0d: got %h want %h", i, get_obs(), exp);
      end
    end
    nvec++;
    if (smm !== 1'b0 || initc !== 1'b0) begin
      nmis++; $display("FAIL restart: got smm=%b rdy=%b want 0 0", smm, initc);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] tbl [6] = '{11'h210, 11'h320, 11'h704, 11'h3AA, 11'h208, 11'h000};
    outv_t exp;
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i]);
      exp = sb.pop_front(); nvec++;
      if (get_obs() !== exp) begin
        nmis++; $display("FAIL reset_mid step %0d: got %h want %h", i, get_obs(), exp);
      end
    end
    nvec++;
    if (get_obs() !== outv_t'('0)) begin
      nmis++; $display("FAIL reset_mid_zero: got %h want 0", get_obs());
    end
  endtask

  // Back-to-back random writes, biased towards completing init so OCWs get exercised.
  task automatic test_back_to_back();
    logic [10:0] s;
    outv_t exp;
    for (int i = 0; i < 400; i++) begin
      s[10]  = ($urandom_range(0, 39) == 0);
      s[9]   = ($urandom_range(0, 3) != 0);
      s[8]   = $urandom_range(0, 1);
      s[7:0] = $urandom_range(0, 255);
      if (!s[8] && $urandom_range(0, 3) != 0) s[4] = 1'b0;
      cycle(s);
      exp = sb.pop_front(); nvec++;
      if (get_obs() !== exp) begin
        nmis++; $display("FAIL random step %0d stim %h: got %h want %h", i, s, get_obs(), exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; write_strobe = 1'b0; address_0 = 1'b0; internal_data_bus = '0;
    m_o = '0; m_st = 0; m_ic4 = 1'b0;
    test_reset();
    test_icw4_path();
    test_icw3_path();
    test_ocw();
    test_ignore_mid();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
